// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch FSM with redirect, stall hold and stale-response drop.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        valid,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);
    typedef enum logic [1:0] {FETCH, HOLD, DROP} state_t;
    state_t      state;
    logic [31:0] fetch_pc;
    logic [31:0] drop_addr;
    assign imem_req  = rst_n && (state != HOLD);
    // DROP keeps the abandoned address on the bus until memory answers it
    assign imem_addr = (state == DROP) ? drop_addr : fetch_pc;
    assign pc_plus4  = pc + 32'd4;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= FETCH;
            fetch_pc    <= RESET_PC;
            pc          <= RESET_PC;
            valid       <= 1'b0;
            instruction <= NOP_INSN;
            misaligned  <= 1'b0;
            drop_addr   <= 32'd0;
        end else begin
            misaligned <= 1'b0;
            if (redirect) begin
                fetch_pc    <= {redirect_pc[31:2], 2'b00};
                valid       <= 1'b0;
                instruction <= NOP_INSN;
                misaligned  <= |redirect_pc[1:0];
                if (!imem_ack && state != HOLD) begin
                    state <= DROP;
                    if (state == FETCH) drop_addr <= fetch_pc;
                end else begin
                    state <= FETCH;
                end
            end else begin
                case (state)
                    FETCH: if (imem_ack) begin
                        instruction <= imem_rdata;
                        pc          <= fetch_pc;
                        valid       <= 1'b1;
                        state       <= HOLD;
                    end
                    HOLD: if (!stall) begin
                        fetch_pc    <= pc_plus4;
                        valid       <= 1'b0;
                        instruction <= NOP_INSN;
                        state       <= FETCH;
                    end
                    DROP: if (imem_ack) state <= FETCH;
                    default: state <= FETCH;
                endcase
            end
        end
    end
endmodule
